seq_decoder: RTL and testbench

SEQ_DECODER -- requirements
Module: seq_decoder

---
 rtl/seq_decoder.sv | 146 ++++++++++++++
 tb/tb_seq_decoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_decoder.sv
// seq_decoder: registered select decoder with one-hot, thermometer,
// active-low one-hot and multi-beat scan modes. Requests arrive on a
// valid/ready handshake, and results leave on a second valid/ready
// handshake through a single output register.
module seq_decoder #(
    parameter  int unsigned SEL_W = 3,
    localparam int unsigned OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [1:0] M_ONEHOT   = 2'b00;
    localparam logic [1:0] M_THERM    = 2'b01;
    localparam logic [1:0] M_SCAN     = 2'b10;
    localparam logic [1:0] M_ONEHOT_N = 2'b11;

    // Highest index; a scan beat at this index is the final one.
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    state_t             state_q, state_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [SEL_W-1:0]   idx_q, idx_d;

    logic               accept;
    logic               xfer;

    // Single bit set at position idx.
    function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] w;
        for (int i = 0; i < OUT_W; i++) begin
            w[i] = (i == int'(idx));
        end
        return w;
    endfunction

    // Bits [idx:0] set. Built bitwise so idx = OUT_W-1 never overflows.
    function automatic logic [OUT_W-1:0] therm(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] w;
        for (int i = 0; i < OUT_W; i++) begin
            w[i] = (i <= int'(idx));
        end
        return w;
    endfunction

    // Handshake qualifiers. in_ready only looks at registered state and
    // out_ready, so there is no path from sel/mode to any output.
    always_comb begin
        in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;
        xfer     = out_valid_q && out_ready;
    end

    // Next-state, output word and scan index selection.
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        idx_d       = idx_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    // Acceptance implies the register is empty or draining
                    // this cycle, so it may be overwritten unconditionally.
                    out_valid_d = 1'b1;
                    unique case (mode)
                        M_ONEHOT:   out_d = onehot(sel);
                        M_THERM:    out_d = therm(sel);
                        M_ONEHOT_N: out_d = ~onehot(sel);
                        M_SCAN: begin
                            out_d = onehot(sel);
                            // A scan starting at the last index is a single
                            // beat and needs no SCAN state.
                            if (sel != LAST_IDX) begin
                                state_d = SCAN;
                                idx_d   = sel;
                            end
                        end
                        default: out_d = out_q;
                    endcase
                end else if (xfer) begin
                    out_valid_d = 1'b0;
                end
            end

            SCAN: begin
                // out_valid stays high for the whole scan; the index and
                // word only move when the current beat is consumed.
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                        out_d = onehot(idx_q + SEL_W'(1));
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                idx_d       = '0;
            end
        endcase
    end

    // State and output registers; reset wins over any accept or transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            idx_q       <= idx_d;
        end
    end

    // Registered outputs straight to the ports.
    always_comb begin
        out       = out_q;
        out_valid = out_valid_q;
        busy      = (state_q == SCAN);
    end

endmodule

// File: tb/tb_seq_decoder.sv
// Self-checking bench for seq_decoder (SEL_W=3). Expected words are pushed
// to a scoreboard queue when a request is accepted and popped when the
// design completes an output transfer.
module tb_seq_decoder;

    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] sel;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic             busy;

    logic [OUT_W-1:0] sb_q[$];
    int               n_chk  = 0;
    int               n_fail = 0;

    seq_decoder #(.SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic drive_slot();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; sel = 3'd2; mode = 2'b10; out_ready = 1'b1;
        drive_slot();
        drive_slot();
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_chk++; if (out !== 8'h00) begin n_fail++; $display("FAIL reset_out got %h want 00", out); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        drive_slot();
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    // Back-to-back accepts; each word must appear exactly one cycle later.
    task automatic test_onehot_sweep();
        for (int k = 0; k <= OUT_W; k++) begin
            logic [OUT_W-1:0] one;
            drive_slot();
            out_ready = 1'b1;
            if (k < OUT_W) begin
                in_valid = 1'b1; sel = 3'(k); mode = 2'b00;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_chk++; if (out_valid !== (k > 0)) begin n_fail++; $display("FAIL sweep_valid k=%0d got %b want %b", k, out_valid, (k > 0)); end
            if (out_valid && out_ready && sb_q.size() > 0) begin
                logic [OUT_W-1:0] exp;
                exp = sb_q.pop_front();
                n_chk++; if (out !== exp) begin n_fail++; $display("FAIL sweep_out k=%0d got %h want %h", k, out, exp); end
            end
            if (k < OUT_W) begin
                n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready k=%0d got %b want 1", k, in_ready); end
                one = 8'h01;
                sb_q.push_back(one << k);
            end
        end
    endtask

    task automatic test_therm_onehotn();
        logic [SEL_W-1:0] t_sel[3]  = '{3'd3, 3'd3, 3'd7};
        logic [1:0]       t_mode[3] = '{2'b01, 2'b11, 2'b01};
        logic [OUT_W-1:0] t_exp[3]  = '{8'h0F, 8'hF7, 8'hFF};
        for (int k = 0; k <= 3; k++) begin
            drive_slot();
            out_ready = 1'b1;
            if (k < 3) begin
                in_valid = 1'b1; sel = t_sel[k]; mode = t_mode[k];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                logic [OUT_W-1:0] exp;
                exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
                n_chk++; if (!(out_valid && out === exp)) begin n_fail++; $display("FAIL therm_onehotn k=%0d got v=%b %h want %h", k, out_valid, out, exp); end
            end
            if (k < 3 && in_ready) sb_q.push_back(t_exp[k]);
        end
    endtask

    task automatic test_backpressure();
        drive_slot();
        in_valid = 1'b1; sel = 3'd5; mode = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        if (in_ready) sb_q.push_back(8'h20);
        drive_slot();
        // A competing request must be ignored while the output is stalled.
        sel = 3'd1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++; if (!(out_valid === 1'b1 && out === 8'h20)) begin n_fail++; $display("FAIL bp_hold c=%0d got v=%b %h want 1 20", c, out_valid, out); end
            n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, in_ready); end
            if (c < 3) drive_slot();
        end
        drive_slot();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        if (out_valid && out_ready) begin
            logic [OUT_W-1:0] exp;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_chk++; if (out !== exp) begin n_fail++; $display("FAIL bp_out got %h want %h", out, exp); end
        end
        drive_slot();
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_single_xfer got %b want 0", out_valid); end
        n_chk++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL bp_sb_left got %0d want 0", sb_q.size()); end
    endtask

    task automatic test_scan();
        drive_slot();
        in_valid = 1'b1; sel = 3'd5; mode = 2'b10; out_ready = 1'b1;
        @(negedge clk);
        if (in_ready) begin
            sb_q.push_back(8'h20); sb_q.push_back(8'h40); sb_q.push_back(8'h80);
        end
        drive_slot();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            logic [OUT_W-1:0] exp;
            if (j > 0) drive_slot();
            @(negedge clk);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_chk++; if (!(out_valid === 1'b1 && out === exp)) begin n_fail++; $display("FAIL scan_beat j=%0d got v=%b %h want %h", j, out_valid, out, exp); end
            n_chk++; if (!(busy === 1'b1 && in_ready === 1'b0)) begin n_fail++; $display("FAIL scan_busy j=%0d got busy=%b in_ready=%b want 1 0", j, busy, in_ready); end
        end
        drive_slot();
        @(negedge clk);
        n_chk++; if (!(busy === 1'b0 && out_valid === 1'b0 && in_ready === 1'b1)) begin n_fail++; $display("FAIL scan_end got busy=%b v=%b in_ready=%b want 0 0 1", busy, out_valid, in_ready); end

        // Scan from the last index: single beat, never busy.
        drive_slot();
        in_valid = 1'b1; sel = 3'd7; mode = 2'b10;
        @(negedge clk);
        if (in_ready) sb_q.push_back(8'h80);
        drive_slot();
        in_valid = 1'b0;
        @(negedge clk);
        begin
            logic [OUT_W-1:0] exp;
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
            n_chk++; if (!(out_valid === 1'b1 && out === exp)) begin n_fail++; $display("FAIL scan7_out got v=%b %h want %h", out_valid, out, exp); end
        end
        n_chk++; if (!(busy === 1'b0 && in_ready === 1'b1)) begin n_fail++; $display("FAIL scan7_busy got busy=%b in_ready=%b want 0 1", busy, in_ready); end
        drive_slot();
        @(negedge clk);
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL scan7_one_beat got %b want 0", out_valid); end
    endtask

    task automatic test_scan_stall_reset();
        bit seen8 = 1'b0;
        drive_slot();
        in_valid = 1'b1; sel = 3'd2; mode = 2'b10; out_ready = 1'b1;
        @(negedge clk);
        if (in_ready) begin
            sb_q.push_back(8'h04); sb_q.push_back(8'h08); sb_q.push_back(8'h10);
            sb_q.push_back(8'h20); sb_q.push_back(8'h40); sb_q.push_back(8'h80);
        end
        drive_slot();
        in_valid = 1'b0;
        for (int t = 0; t < 20 && !seen8; t++) begin
            if (t > 0) drive_slot();
            out_ready = t[0];
            @(negedge clk);
            // Stalled or not, the presented word must be the next expected.
            n_chk++; if (!(out_valid === 1'b1 && sb_q.size() > 0 && out === sb_q[0])) begin n_fail++; $display("FAIL stall_word t=%0d got v=%b %h", t, out_valid, out); end
            if (out_valid && out_ready && sb_q.size() > 0) begin
                if (sb_q.pop_front() == 8'h08) seen8 = 1'b1;
            end
        end
        n_chk++; if (!seen8) begin n_fail++; $display("FAIL stall_timeout got no 08 beat want 08"); end
        drive_slot();
        rst = 1'b1; out_ready = 1'b0;
        drive_slot();
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (!(out_valid === 1'b0 && out === 8'h00 && busy === 1'b0)) begin n_fail++; $display("FAIL abort_state got v=%b %h busy=%b want 0 00 0", out_valid, out, busy); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
        sb_q.delete();
        for (int c = 0; c < 3; c++) begin
            drive_slot();
            @(negedge clk);
            n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_beat c=%0d got v=%b %h want 0", c, out_valid, out); end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; sel = '0; mode = '0; out_ready = 1'b0;
        test_reset();
        test_onehot_sweep();
        test_therm_onehotn();
        test_backpressure();
        test_scan();
        test_scan_stall_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
